// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wb
// Brief    : Direct-mapped, write-back, write-allocate data cache with a
//            word-wide req/ack backing-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wb #(
   parameter int LINE_NUM   = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic        re,
   input  logic        we,
   output logic [31:0] dout,
   output logic        done,
   output logic [31:0] hit_cnt,
   output logic [31:0] tot_cnt,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int c_OFF_W = $clog2(LINE_WORDS);
   localparam int c_IDX_W = $clog2(LINE_NUM);
   localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;
   localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(LINE_WORDS - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_WB     = 2'd1;
   localparam logic [1:0] c_REFILL = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic [LINE_NUM-1:0] r_valid;
   logic [LINE_NUM-1:0] r_dirty;
   logic [c_TAG_W-1:0]  r_tag  [LINE_NUM];
   logic [31:0]         r_data [LINE_NUM][LINE_WORDS];
   logic [c_IDX_W-1:0]  r_miss_idx;
   logic [c_TAG_W-1:0]  r_miss_tag;
   logic [c_OFF_W-1:0]  r_beat;
   logic                r_miss_seen;
   logic [31:0]         r_hit_cnt;
   logic [31:0]         r_tot_cnt;

   logic [c_OFF_W-1:0]  w_off;
   logic [c_IDX_W-1:0]  w_idx;
   logic [c_TAG_W-1:0]  w_tag;
   logic                w_req;
   logic                w_hit;
   logic                w_last_ack;
   logic                w_unused;

   assign w_off      = addr[2 +: c_OFF_W];
   assign w_idx      = addr[2 + c_OFF_W +: c_IDX_W];
   assign w_tag      = addr[31 -: c_TAG_W];
   assign w_req      = re | we;
   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_last_ack = mem_ack && (r_beat == c_LAST_BEAT);
   assign w_unused   = &{1'b0, addr[1:0]};

   assign hit_cnt = r_hit_cnt;
   assign tot_cnt = r_tot_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (w_req && !w_hit)
                      w_next_state = (r_valid[w_idx] && r_dirty[w_idx]) ? c_WB : c_REFILL;
         c_WB:     if (w_last_ack) w_next_state = c_REFILL;
         c_REFILL: if (w_last_ack) w_next_state = c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      done      = 1'b0;
      dout      = 32'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (r_state)
         c_IDLE: begin
            done = w_req && w_hit;
            if (w_hit) dout = r_data[w_idx][w_off];
         end
         c_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_tag[r_miss_idx], r_miss_idx, r_beat, 2'b00};
            mem_wdata = r_data[r_miss_idx][r_beat];
         end
         c_REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {r_miss_tag, r_miss_idx, r_beat, 2'b00};
         end
         default: ;
      endcase
   end

   // Control state: only valid/dirty are reset, line contents are not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= '0;
         r_dirty     <= '0;
         r_beat      <= '0;
         r_miss_seen <= 1'b0;
         r_hit_cnt   <= 32'd0;
         r_tot_cnt   <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (we && w_hit) begin
                  r_dirty[w_idx] <= 1'b1;
               end else if (w_req && !w_hit) begin
                  r_beat      <= '0;
                  r_miss_seen <= 1'b1;
               end
            end
            c_WB: if (mem_ack) r_beat <= w_last_ack ? '0 : r_beat + c_OFF_W'(1);
            c_REFILL: if (mem_ack) begin
               r_beat <= r_beat + c_OFF_W'(1);
               if (w_last_ack) begin
                  r_valid[r_miss_idx] <= 1'b1;
                  r_dirty[r_miss_idx] <= 1'b0;
                  // A requester that walked away must not leave a stale miss mark.
                  if (!w_req) r_miss_seen <= 1'b0;
               end
            end
            default: ;
         endcase
         if (done) begin
            if (r_tot_cnt != 32'hFFFF_FFFF) r_tot_cnt <= r_tot_cnt + 32'd1;
            if (!r_miss_seen && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            r_miss_seen <= 1'b0;
         end
      end
   end

   // Line storage and the latched miss target (index/tag survive a dropped request).
   always_ff @(posedge clk) begin
      if (r_state == c_IDLE && w_req && !w_hit) begin
         r_miss_idx <= w_idx;
         r_miss_tag <= w_tag;
      end
      if (r_state == c_IDLE && we && w_hit)
         r_data[w_idx][w_off] <= din;
      if (r_state == c_REFILL && mem_ack)
         r_data[r_miss_idx][r_beat] <= mem_rdata;
      if (r_state == c_REFILL && w_last_ack)
         r_tag[r_miss_idx] <= r_miss_tag;
   end

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wb
// Brief    : Directed self-checking bench for dcache_wb with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = 32'd0;
   logic [31:0] din = 32'd0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [31:0] dout;
   logic        done;
   logic [31:0] hit_cnt;
   logic [31:0] tot_cnt;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack = 1'b1;

   dcache_wb dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .din       (din),
      .re        (re),
      .we        (we),
      .dout      (dout),
      .done      (done),
      .hit_cnt   (hit_cnt),
      .tot_cnt   (tot_cnt),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   // Backing memory: word = 0x5A000000 | byte address, except where written.
   logic [31:0] mem [4096];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic        log_we   [$];
   bit          ack_tied = 1'b1;
   int          wcnt = 0;
   logic [31:0] first_addr = 32'd0;
   bit          unstable = 1'b0;

   assign mem_rdata = mem[mem_addr[13:2]];

   always @(negedge clk) begin
      if (mem_req) begin
         wcnt = wcnt + 1;
         if (wcnt == 1) first_addr = mem_addr;
         else if (mem_addr != first_addr) unstable = 1'b1;
         mem_ack = ack_tied ? 1'b1 : (wcnt == 3);
         if (mem_ack) begin
            wcnt = 0;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_we ? mem_wdata : mem_rdata);
            log_we.push_back(mem_we);
            if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
         end
      end else begin
         wcnt    = 0;
         mem_ack = ack_tied;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns extra cycles until done and the data seen then.
   task automatic run_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int cyc, output logic [31:0] rd);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      rd   = 32'd0;
      log_addr.delete();
      log_data.delete();
      log_we.delete();
      re = r; we = w; addr = a; din = d;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            rd   = dout;
         end else begin
            cyc++;
         end
      end
      check("req_done", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      re = 1'b0; we = 1'b0;
   endtask

   logic [31:0] rd;
   int          cyc;
   logic [31:0] exp_a;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | 32'(i * 4);
      mem[32'h2000 >> 2] = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dout", dout, 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_tot_cnt", tot_cnt, 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Cold read, clean miss.
      run_req(1'b1, 1'b0, 32'h2000, 32'd0, cyc, rd);
      check("cold_cycles", 32'(cyc), 32'd5);
      check("cold_dout", rd, 32'hDEAD_BEEF);
      check("cold_nbeats", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         exp_a = 32'h2000 + 32'(i * 4);
         check("cold_refill_addr", log_addr[i], exp_a);
         check("cold_refill_we", 32'(log_we[i]), 32'd0);
      end
      check("cold_tot", tot_cnt, 32'd1);
      check("cold_hit", hit_cnt, 32'd0);

      // Write hit, then read it back.
      run_req(1'b0, 1'b1, 32'h2004, 32'h1234_5678, cyc, rd);
      check("wr_hit_cycles", 32'(cyc), 32'd0);
      run_req(1'b1, 1'b0, 32'h2004, 32'd0, cyc, rd);
      check("rd_hit_cycles", 32'(cyc), 32'd0);
      check("rd_hit_dout", rd, 32'h1234_5678);
      check("hit_hit_cnt", hit_cnt, 32'd2);
      check("hit_tot_cnt", tot_cnt, 32'd3);

      // Dirty eviction.
      run_req(1'b1, 1'b0, 32'h2100, 32'd0, cyc, rd);
      check("evict_cycles", 32'(cyc), 32'd9);
      check("evict_nbeats", 32'(log_addr.size()), 32'd8);
      for (int i = 0; i < 4; i++) begin
         exp_a = 32'h2000 + 32'(i * 4);
         check("wb_addr", log_addr[i], exp_a);
         check("wb_we", 32'(log_we[i]), 32'd1);
         exp_a = 32'h2100 + 32'(i * 4);
         check("evict_refill_addr", log_addr[i+4], exp_a);
         check("evict_refill_we", 32'(log_we[i+4]), 32'd0);
      end
      check("wb_data0", log_data[0], 32'hDEAD_BEEF);
      check("wb_data1", log_data[1], 32'h1234_5678);
      check("wb_data2", log_data[2], 32'h5A00_2008);
      check("evict_dout", rd, 32'h5A00_2100);
      check("evict_tot", tot_cnt, 32'd4);
      check("evict_hit", hit_cnt, 32'd2);

      // Wait states: ack every third cycle.
      ack_tied = 1'b0;
      unstable = 1'b0;
      run_req(1'b1, 1'b0, 32'h3040, 32'd0, cyc, rd);
      check("ws_cycles", 32'(cyc), 32'd13);
      check("ws_addr_stable", 32'(unstable), 32'd0);
      check("ws_nbeats", 32'(log_addr.size()), 32'd4);
      check("ws_dout", rd, 32'h5A00_3040);
      check("ws_tot", tot_cnt, 32'd5);
      ack_tied = 1'b1;

      // Reset during refill cycle 2.
      re = 1'b1; addr = 32'h3080;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_mem_req", 32'(mem_req), 32'd0);
      check("mid_rst_tot", tot_cnt, 32'd0);
      check("mid_rst_hit", hit_cnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      re  = 1'b0;
      @(posedge clk);
      #1;
      run_req(1'b1, 1'b0, 32'h3080, 32'd0, cyc, rd);
      check("post_rst_cycles", 32'(cyc), 32'd5);
      check("post_rst_nbeats", 32'(log_addr.size()), 32'd4);
      check("post_rst_addr0", log_addr[0], 32'h3080);
      check("post_rst_dout", rd, 32'h5A00_3080);
      check("post_rst_tot", tot_cnt, 32'd1);
      check("post_rst_hit", hit_cnt, 32'd0);

      // re and we together on a resident line: write wins, line turns dirty.
      run_req(1'b1, 1'b1, 32'h3084, 32'hCAFE_F00D, cyc, rd);
      check("rw_cycles", 32'(cyc), 32'd0);
      check("rw_tot", tot_cnt, 32'd2);
      check("rw_hit", hit_cnt, 32'd1);
      run_req(1'b1, 1'b0, 32'h3180, 32'd0, cyc, rd);
      check("rw_evict_cycles", 32'(cyc), 32'd9);
      check("rw_wb_addr1", log_addr[1], 32'h3084);
      check("rw_wb_we1", 32'(log_we[1]), 32'd1);
      check("rw_wb_data1", log_data[1], 32'hCAFE_F00D);
      check("rw_evict_tot", tot_cnt, 32'd3);
      check("rw_evict_hit", hit_cnt, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache. It is the responder for the MEM stage's data-memory request interface: `re`, `we`, `addr` and `din` in; `dout`, `done`, `hit_cnt` and `tot_cnt` out. Misses and dirty evictions go to a word-wide backing-memory port with a req/ack handshake. The MEM stage stalls the pipeline while `done` is low.

## Interface
- `LINE_NUM`, 16: number of lines; power of 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `din`  in  32  write data.
- `re`  in  1  read request.
- `we`  in  1  write request.
- `dout`  out  32  read data; valid while `done`=1.
- `done`  out  1  request completes this cycle.
- `hit_cnt`  out  32  number of completed requests that hit on first lookup.
- `tot_cnt`  out  32  number of completed requests.
- `mem_req`  out  1  backing-memory transaction request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_wdata`  out  32  write-beat data.
- `mem_rdata`  in  32  read-beat data; valid with `mem_ack`.
- `mem_ack`  in  1  beat accepted or returned; may assert in the same cycle as `mem_req`.

## Operation
- **Address split** (defaults):
  - offset = `addr`[3:2]
  - index = `addr`[7:4]
  - tag = `addr`[31:8]
  - widths derive from the parameters.
- **Per-line state:** valid, dirty, tag, data words. Reset clears valid and dirty only; data and tag contents are unspecified.
- **Request rules:**
  - Requester holds `addr`, `din`, `re` and `we` stable until the cycle `done`=1.
  - `we` takes priority if both `re` and `we` are asserted.
  - No request (`re`=`we`=0) leaves all state unchanged.
- **FSM states:** IDLE, WB, REFILL.
- **IDLE:**
  - hit = valid[index] & tag match.
  - `done` = (`re`|`we`) & hit, combinational.
  - `dout` = data[index][offset] on hit, else 0.
  - Write hit: at the edge, write `din` to the word and set dirty.
  - Miss with dirty victim: go to WB, beat counter = 0, set miss_seen.
  - Miss with clean or invalid victim: go to REFILL, beat counter = 0, set miss_seen.
- **WB:**
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, index, beat, 2'b00}; `mem_wdata` = victim word[beat].
  - Each `mem_ack` increments beat. The ack on the last beat moves to REFILL with beat = 0.
- **REFILL:**
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {req tag, index, beat, 2'b00}.
  - Each `mem_ack` writes `mem_rdata` into word[beat] and increments beat.
  - On the last ack: write the tag, set valid=1, dirty=0, return to IDLE.
  - The request then hits in IDLE.
- **Counters** (both saturate at 32'hFFFF_FFFF):
  - On every edge with `done`=1: `tot_cnt` += 1.
  - If miss_seen=0 on that edge: `hit_cnt` += 1. miss_seen clears on that edge.
- **Outside WB and REFILL:** `mem_req`=0, `mem_we`=0; `mem_addr` and `mem_wdata` are don't-care.
- **Request dropped mid-miss** (`re`/`we` fall while in WB or REFILL): the line operation still completes; miss_seen clears on return to IDLE.
- **Reset mid-operation:**
  - FSM returns to IDLE; valid, dirty, counters, beat and miss_seen are all cleared.
  - An in-flight `mem_req` drops immediately, and any pending dirty data is lost.

## Timing
- **Reset values:** `done`=0, `dout`=0, `hit_cnt`=0, `tot_cnt`=0, `mem_req`=0, `mem_we`=0.
- **Hit:** `done` in the request's first cycle (0 extra cycles).
- **Clean miss** with `mem_ack` tied high:
  - cycle 0 lookup;
  - cycles 1–4 refill beats;
  - cycle 5 hit, `done`=1.
  - Each memory wait state adds 1 cycle.
- **Dirty miss** with `mem_ack` tied high: 4 write beats in cycles 1–4, 4 read beats in cycles 5–8, `done` in cycle 9.
- `mem_addr`, `mem_we` and `mem_wdata` are stable from `mem_req` rising until `mem_ack`.
- Never more than one beat outstanding.

## Test plan
- **Reset, then cold read:** read 0x2000 with memory word 0x2000 = 0xDEADBEEF and ack tied high.
  - `done` at cycle 5, `dout`=0xDEADBEEF.
  - REFILL addresses 0x2000, 0x2004, 0x2008, 0x200C.
  - Counters: `tot_cnt`=1, `hit_cnt`=0.
- **Write hit:** write 0x12345678 to 0x2004, then read 0x2004.
  - Both complete in 0 extra cycles, `dout`=0x12345678.
  - Counters: `hit_cnt`=2, `tot_cnt`=3.
- **Dirty eviction:** read 0x2100 (same index, different tag).
  - WB beats write 0x2000–0x200C, with 0x12345678 at 0x2004.
  - REFILL then fetches 0x2100–0x210C; `done` at cycle 9.
- **Wait states:** `mem_ack` asserted only every 3rd cycle.
  - `mem_addr` stays constant across each beat.
  - Clean-miss `done` at cycle 1 + 4×3 = 13.
- **Reset mid-refill:** assert `rst` in cycle 2 of a REFILL.
  - `mem_req` falls immediately; counters read 0.
  - The next read of the same address misses again (full refill).
- **`re`=`we`=1 to a resident line:** the write is performed and dirty is set; `tot_cnt` increments once.
